// File: rtl/tile_row_serializer.sv
// ----------------------------------------------------------------------------
// tile_row_serializer
//
// Takes 96-bit tile-ROM row words from pixel_drawer and streams them out as
// 3-bit RGB pixels, one pixel per pixel-request strobe. A holding register
// in front of the active shifter lets the next row load on the same edge
// that consumes the last pixel of the current row, so rows stream back to
// back with no gap pixel.
//
// Build option:
//   TILE_SER_LSB_FIRST_EN  defined   -> pixel 0 = row_data_i[2:0], shift right
//                          undefined -> pixel 0 = row_data_i[95:93], shift left
//
// Ports:
//   clk_i           in   system clock, rising edge
//   rst_ni          in   asynchronous active-low reset
//   row_data_i      in   row word from tile ROM
//   row_valid_i     in   row_data_i is valid
//   row_ready_o     out  holding register empty, a row can be accepted
//   pixel_req_i     in   one-cycle strobe requesting the next pixel
//   pixel_o         out  current pixel colour (registered)
//   pixel_valid_o   out  pulse: pixel_o updated with real data this cycle
//   row_last_o      out  pulse with pixel_valid_o on the last pixel of a row
//   underrun_o      out  sticky: a request arrived with no pixel available
//   underrun_clr_i  in   synchronous clear of underrun_o (set wins)
// ----------------------------------------------------------------------------
module tile_row_serializer #(
    parameter int unsigned ROM_DATA_WIDTH = 96,
    parameter int unsigned PIXEL_WIDTH    = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ROM_DATA_WIDTH-1:0] row_data_i,
    input  logic                      row_valid_i,
    output logic                      row_ready_o,
    input  logic                      pixel_req_i,
    output logic [PIXEL_WIDTH-1:0]    pixel_o,
    output logic                      pixel_valid_o,
    output logic                      row_last_o,
    output logic                      underrun_o,
    input  logic                      underrun_clr_i
);

    // ROM_DATA_WIDTH must be an exact multiple of PIXEL_WIDTH.
    localparam int unsigned PIXELS_PER_ROW = ROM_DATA_WIDTH / PIXEL_WIDTH;
    localparam int unsigned CNT_W          = $clog2(PIXELS_PER_ROW + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIXELS_PER_ROW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [ROM_DATA_WIDTH-1:0] r_hold;
    logic                      r_hold_full;
    logic [ROM_DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]          r_cnt;     // pixels left in shifter, 0 = empty
    logic [PIXEL_WIDTH-1:0]    r_pixel;
    logic                      r_pixel_valid;
    logic                      r_row_last;
    logic                      r_underrun;

    logic [PIXEL_WIDTH-1:0]    w_pixel_next;
    logic [ROM_DATA_WIDTH-1:0] w_shift_next;
    logic                      w_accept;
    logic                      w_shift_empty;

`ifdef TILE_SER_LSB_FIRST_EN
    assign w_pixel_next = r_shift[PIXEL_WIDTH-1:0];
    assign w_shift_next = {{PIXEL_WIDTH{1'b0}}, r_shift[ROM_DATA_WIDTH-1:PIXEL_WIDTH]};
`else
    assign w_pixel_next = r_shift[ROM_DATA_WIDTH-1 -: PIXEL_WIDTH];
    assign w_shift_next = {r_shift[ROM_DATA_WIDTH-PIXEL_WIDTH-1:0], {PIXEL_WIDTH{1'b0}}};
`endif

    assign row_ready_o   = ~r_hold_full;
    assign w_accept      = row_valid_i & ~r_hold_full;
    assign w_shift_empty = (r_cnt == CNT_ZERO);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_cnt         <= CNT_ZERO;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_row_last    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_row_last    <= 1'b0;

            if (underrun_clr_i) begin
                r_underrun <= 1'b0;
            end

            // Accept never coincides with a shifter load: ready is low while
            // the holding register is full.
            if (w_accept) begin
                r_hold      <= row_data_i;
                r_hold_full <= 1'b1;
            end

            if (pixel_req_i && !w_shift_empty) begin
                r_pixel       <= w_pixel_next;
                r_pixel_valid <= 1'b1;
                r_row_last    <= (r_cnt == CNT_ONE);
                if (r_cnt == CNT_ONE && r_hold_full) begin
                    // Last pixel out and next row waiting: reload seamlessly.
                    r_shift     <= r_hold;
                    r_cnt       <= CNT_FULL;
                    r_hold_full <= 1'b0;
                end else begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - CNT_ONE;
                end
            end else begin
                if (pixel_req_i) begin
                    // Shifter empty: underrun, even if a load happens now.
                    r_pixel    <= '0;
                    r_underrun <= 1'b1;
                end
                if (w_shift_empty && r_hold_full) begin
                    r_shift     <= r_hold;
                    r_cnt       <= CNT_FULL;
                    r_hold_full <= 1'b0;
                end
            end
        end
    end

    assign pixel_o       = r_pixel;
    assign pixel_valid_o = r_pixel_valid;
    assign row_last_o    = r_row_last;
    assign underrun_o    = r_underrun;

endmodule

// File: tb/tb_tile_row_serializer.sv
module tb_tile_row_serializer;

    logic        clk_i;
    logic        rst_ni;
    logic [95:0] row_data_i;
    logic        row_valid_i;
    logic        row_ready_o;
    logic        pixel_req_i;
    logic [2:0]  pixel_o;
    logic        pixel_valid_o;
    logic        row_last_o;
    logic        underrun_o;
    logic        underrun_clr_i;

    int n_run;
    int n_fail;

    localparam logic [95:0] ROW_TEST = 96'hFAC688_000000_000000_000007;
    localparam logic [95:0] ROW_001  = 96'h249249249249249249249249;
    localparam logic [95:0] ROW_010  = 96'h492492492492492492492492;
    localparam logic [95:0] ROW_111  = 96'hFFFFFFFFFFFFFFFFFFFFFFFF;

    tile_row_serializer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .row_data_i     (row_data_i),
        .row_valid_i    (row_valid_i),
        .row_ready_o    (row_ready_o),
        .pixel_req_i    (pixel_req_i),
        .pixel_o        (pixel_o),
        .pixel_valid_o  (pixel_valid_o),
        .row_last_o     (row_last_o),
        .underrun_o     (underrun_o),
        .underrun_clr_i (underrun_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        row_valid_i    = 1'b0;
        row_data_i     = '0;
        pixel_req_i    = 1'b0;
        underrun_clr_i = 1'b0;
        rst_ni         = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // Hand-derived pixels of ROW_TEST in MSB-first order.
    function automatic logic [2:0] test_row_pixel(input int i);
        logic [2:0] tbl [32];
        for (int k = 0; k < 32; k++) tbl[k] = 3'd0;
        tbl[0]  = 3'd7; tbl[1] = 3'd6; tbl[2] = 3'd5; tbl[3] = 3'd4;
        tbl[4]  = 3'd3; tbl[5] = 3'd2; tbl[6] = 3'd1; tbl[7] = 3'd0;
        tbl[31] = 3'd7;
`ifdef TILE_SER_LSB_FIRST_EN
        return tbl[31 - i];
`else
        return tbl[i];
`endif
    endfunction

    // Push one row into an idle serializer and let it load into the shifter.
    task automatic load_row(input logic [95:0] data);
        row_valid_i = 1'b1;
        row_data_i  = data;
        step();                       // accept
        row_valid_i = 1'b0;
        row_data_i  = '0;
        step();                       // load into shifter
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if ({pixel_o, pixel_valid_o, row_last_o, underrun_o, row_ready_o} !== 7'b000_0_0_0_1) begin
            n_fail++;
            $display("FAIL reset_state: got px=%b v=%b last=%b ur=%b rdy=%b, need 000 0 0 0 1",
                     pixel_o, pixel_valid_o, row_last_o, underrun_o, row_ready_o);
        end
    endtask

    task automatic test_single_row();
        do_reset();
        row_valid_i = 1'b1;
        row_data_i  = ROM_TEST_SEL();
        step();
        row_valid_i = 1'b0;
        n_run++;
        if (row_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_held: got %b need 0", row_ready_o);
        end
        step();
        n_run++;
        if (row_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_after_load: got %b need 1", row_ready_o);
        end
        pixel_req_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            n_run++;
            if (pixel_valid_o !== 1'b1 || pixel_o !== test_row_pixel(i) ||
                row_last_o !== (i == 31) || row_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL single_pixel[%0d]: got v=%b px=%b last=%b rdy=%b need 1 %b %b 1",
                         i, pixel_valid_o, pixel_o, row_last_o, row_ready_o,
                         test_row_pixel(i), (i == 31));
            end
        end
        pixel_req_i = 1'b0;
        step();
        n_run++;
        if (pixel_valid_o !== 1'b0 || row_last_o !== 1'b0 || pixel_o !== test_row_pixel(31)) begin
            n_fail++;
            $display("FAIL single_idle_after: got v=%b last=%b px=%b need 0 0 %b",
                     pixel_valid_o, row_last_o, pixel_o, test_row_pixel(31));
        end
    endtask

    function automatic logic [95:0] ROM_TEST_SEL();
        return ROW_TEST;
    endfunction

    task automatic test_back_to_back();
        do_reset();
        row_valid_i = 1'b1;
        row_data_i  = ROW_001;
        step();                       // accept first row
        row_data_i = ROW_010;         // second row offered immediately
        n_run++;
        if (row_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall: got rdy=%b need 0", row_ready_o);
        end
        step();                       // first row loads, second still waiting
        n_run++;
        if (row_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after_load: got rdy=%b need 1", row_ready_o);
        end
        pixel_req_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (i == 0) begin
                row_valid_i = 1'b0;   // second row accepted on this edge
                row_data_i  = '0;
            end
            n_run++;
            if (pixel_valid_o !== 1'b1 || pixel_o !== ((i < 32) ? 3'b001 : 3'b010) ||
                row_last_o !== (i == 31 || i == 63)) begin
                n_fail++;
                $display("FAIL b2b_pixel[%0d]: got v=%b px=%b last=%b need 1 %b %b",
                         i, pixel_valid_o, pixel_o, row_last_o,
                         ((i < 32) ? 3'b001 : 3'b010), (i == 31 || i == 63));
            end
        end
        step();                       // 65th request finds nothing
        pixel_req_i = 1'b0;
        n_run++;
        if (pixel_valid_o !== 1'b0 || underrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_duplicate: got v=%b ur=%b need 0 1", pixel_valid_o, underrun_o);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        pixel_req_i = 1'b1;
        step();
        pixel_req_i = 1'b0;
        n_run++;
        if (pixel_valid_o !== 1'b0 || underrun_o !== 1'b1 || pixel_o !== 3'b000) begin
            n_fail++;
            $display("FAIL underrun_set: got v=%b ur=%b px=%b need 0 1 000",
                     pixel_valid_o, underrun_o, pixel_o);
        end
        step();
        n_run++;
        if (underrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_sticky: got %b need 1", underrun_o);
        end
        underrun_clr_i = 1'b1;
        step();
        underrun_clr_i = 1'b0;
        n_run++;
        if (underrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear: got %b need 0", underrun_o);
        end
        underrun_clr_i = 1'b1;
        pixel_req_i    = 1'b1;
        step();
        underrun_clr_i = 1'b0;
        pixel_req_i    = 1'b0;
        n_run++;
        if (underrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set_wins: got %b need 1", underrun_o);
        end
    endtask

    task automatic test_sparse();
        int pulses;
        pulses = 0;
        do_reset();
        load_row(ROW_TEST);
        for (int i = 0; i < 32; i++) begin
            pixel_req_i = 1'b1;
            step();
            pixel_req_i = 1'b0;
            if (pixel_valid_o === 1'b1) pulses++;
            n_run++;
            if (pixel_valid_o !== 1'b1 || pixel_o !== test_row_pixel(i)) begin
                n_fail++;
                $display("FAIL sparse_pixel[%0d]: got v=%b px=%b need 1 %b",
                         i, pixel_valid_o, pixel_o, test_row_pixel(i));
            end
            for (int g = 0; g < 4; g++) begin
                step();
                if (pixel_valid_o === 1'b1) pulses++;
                n_run++;
                if (pixel_valid_o !== 1'b0 || pixel_o !== test_row_pixel(i)) begin
                    n_fail++;
                    $display("FAIL sparse_hold[%0d.%0d]: got v=%b px=%b need 0 %b",
                             i, g, pixel_valid_o, pixel_o, test_row_pixel(i));
                end
            end
        end
        n_run++;
        if (pulses != 32 || underrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_count: got pulses=%0d ur=%b need 32 0", pulses, underrun_o);
        end
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        load_row(ROW_111);
        row_valid_i = 1'b1;
        row_data_i  = ROW_010;
        step();                       // second row now held
        row_valid_i = 1'b0;
        row_data_i  = '0;
        pixel_req_i = 1'b1;
        for (int i = 0; i < 11; i++) step();
        pixel_req_i = 1'b0;
        n_run++;
        if (pixel_valid_o !== 1'b1 || pixel_o !== 3'b111 || row_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_before: got v=%b px=%b rdy=%b need 1 111 0",
                     pixel_valid_o, pixel_o, row_ready_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_run++;
        if ({pixel_o, pixel_valid_o, row_last_o, underrun_o, row_ready_o} !== 7'b000_0_0_0_1) begin
            n_fail++;
            $display("FAIL midrst_async: got px=%b v=%b last=%b ur=%b rdy=%b need 000 0 0 0 1",
                     pixel_o, pixel_valid_o, row_last_o, underrun_o, row_ready_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        step();
        n_run++;
        if (row_ready_o !== 1'b1 || pixel_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: got rdy=%b v=%b need 1 0", row_ready_o, pixel_valid_o);
        end
        pixel_req_i = 1'b1;
        step();
        pixel_req_i = 1'b0;
        n_run++;
        if (pixel_valid_o !== 1'b0 || underrun_o !== 1'b1 || pixel_o !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_no_stale: got v=%b ur=%b px=%b need 0 1 000",
                     pixel_valid_o, underrun_o, pixel_o);
        end
    endtask

`ifdef TILE_SER_LSB_FIRST_EN
    task automatic test_lsb_first();
        do_reset();
        load_row(96'h53);
        pixel_req_i = 1'b1;
        step();
        n_run++;
        if (pixel_o !== 3'b011 || pixel_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_pixel0: got px=%b v=%b need 011 1", pixel_o, pixel_valid_o);
        end
        step();
        pixel_req_i = 1'b0;
        n_run++;
        if (pixel_o !== 3'b010 || pixel_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_pixel1: got px=%b v=%b need 010 1", pixel_o, pixel_valid_o);
        end
    endtask
`endif

    initial begin
        n_run          = 0;
        n_fail         = 0;
        rst_ni         = 1'b0;
        row_data_i     = '0;
        row_valid_i    = 1'b0;
        pixel_req_i    = 1'b0;
        underrun_clr_i = 1'b0;

        test_reset();
        test_single_row();
        test_back_to_back();
        test_underrun();
        test_sparse();
        test_reset_mid_row();
`ifdef TILE_SER_LSB_FIRST_EN
        test_lsb_first();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
